// File: rtl/sram_stream_reader_if.sv
// rtl/sram_stream_reader_if.sv - control slave, SRAM port-2 and stream signals of the read-DMA
interface sram_stream_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [1:0]        ctrl_address;
  logic              ctrl_chipselect;
  logic              ctrl_write;
  logic [31:0]       ctrl_writedata;
  logic              ctrl_read;
  logic [31:0]       ctrl_readdata;
  logic [ADDR_W-1:0] sram_address;
  logic              sram_chipselect;
  logic [DATA_W-1:0] sram_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;
  logic              irq;

  // master: the reader itself, which masters the SRAM port and the stream
  modport master (
    input  ctrl_address, ctrl_chipselect, ctrl_write, ctrl_writedata, ctrl_read,
    output ctrl_readdata,
    output sram_address, sram_chipselect,
    input  sram_readdata,
    output st_data, st_valid, st_sop, st_eop,
    input  st_ready,
    output irq
  );

  modport slave (
    output ctrl_address, ctrl_chipselect, ctrl_write, ctrl_writedata, ctrl_read,
    input  ctrl_readdata,
    input  sram_address, sram_chipselect,
    output sram_readdata,
    input  st_data, st_valid, st_sop, st_eop,
    output st_ready,
    input  irq
  );
endinterface

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - SRAM port-2 read-DMA emitting a packetised ready/valid stream
module sram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input logic                  clk,
  input logic                  reset,
  sram_stream_reader_if.master bus
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] issue_addr;
  logic [LEN_W-1:0]  length;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  remain;
  logic              busy;
  logic              done;
  logic              irq_en;
  logic              first;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

  logic              reg_wr;
  logic              go;
  logic              clr_done;
  logic              set_done;
  logic              st_valid;
  logic              pop;
  logic              issue;
  logic [LEN_W-1:0]  wr_len;
  logic [LEN_W-1:0]  len_sat;
  logic [2:0]        occupancy;
  logic              unused_wdata;

  assign reg_wr       = bus.ctrl_chipselect & bus.ctrl_write;
  assign wr_len       = bus.ctrl_writedata[LEN_W-1:0];
  assign len_sat      = (wr_len > MAX_LEN) ? MAX_LEN : wr_len;
  assign go           = reg_wr && (bus.ctrl_address == 2'd2) && bus.ctrl_writedata[0] && (state == IDLE);
  assign clr_done     = reg_wr && (bus.ctrl_address == 2'd2) && bus.ctrl_writedata[2];
  assign unused_wdata = ^bus.ctrl_writedata[31:LEN_W];

  assign st_valid = (fifo_count != 2'd0);
  assign pop      = st_valid & bus.st_ready;

  // Words already owed to the FIFO after this cycle's pop; a new read must fit in the 2 slots.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && (issue_cnt != '0) && (occupancy < 3'd2);
  assign set_done  = (state == FINISH) || ((state == RUN) && pop && (remain == LEN_W'(1)));

  assign bus.sram_address    = issue_addr;
  assign bus.sram_chipselect = issue;
  assign bus.st_valid        = st_valid;
  assign bus.st_data         = fifo_mem[rd_ptr];
  assign bus.st_sop          = st_valid & first;
  assign bus.st_eop          = st_valid & (remain == LEN_W'(1));
  assign bus.irq             = done & irq_en;

  always_comb begin
    bus.ctrl_readdata = '0;
    if (bus.ctrl_chipselect && bus.ctrl_read) begin
      case (bus.ctrl_address)
        2'd0:    bus.ctrl_readdata = 32'(start_addr);
        2'd1:    bus.ctrl_readdata = 32'(length);
        2'd2:    bus.ctrl_readdata = {29'b0, irq_en, done, busy};
        default: bus.ctrl_readdata = 32'(remain);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_addr  <= '0;
      issue_addr  <= '0;
      length      <= '0;
      issue_cnt   <= '0;
      remain      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      irq_en      <= 1'b0;
      first       <= 1'b0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (reg_wr && (bus.ctrl_address == 2'd0) && !busy)
        start_addr <= bus.ctrl_writedata[ADDR_W-1:0];
      if (reg_wr && (bus.ctrl_address == 2'd1) && !busy)
        length <= len_sat;
      if (reg_wr && (bus.ctrl_address == 2'd2))
        irq_en <= bus.ctrl_writedata[1];

      if (set_done)
        done <= 1'b1;
      else if (clr_done)
        done <= 1'b0;

      // SRAM data for a read issued last cycle is valid now
      inflight <= issue;
      if (inflight) begin
        fifo_mem[wr_ptr] <= bus.sram_readdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (go) begin
            if (length == '0) begin
              state <= FINISH;
            end else begin
              state      <= RUN;
              busy       <= 1'b1;
              issue_addr <= start_addr;
              issue_cnt  <= length;
              remain     <= length;
              first      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issue_addr <= issue_addr + 1'b1;
            issue_cnt  <= issue_cnt - 1'b1;
          end
          if (pop) begin
            first  <= 1'b0;
            remain <= remain - 1'b1;
            if (remain == LEN_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - randomized scoreboard bench for sram_stream_reader
module tb_sram_stream_reader;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sram_stream_reader_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  sram_stream_reader #(.ADDR_W(11), .DATA_W(32), .LEN_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM port 2: registered address, unregistered data
  logic [31:0] mem [2048];
  logic [10:0] addr_q = '0;
  always @(posedge clk) addr_q <= bus.sram_address;
  assign bus.sram_readdata = mem[addr_q];

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t exp_q[$];
  int    addr_exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    ready_mode = 0;
  int    beats_seen = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string nm, int act, int exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endfunction

  initial begin
    bus.st_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.st_ready = (ready_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, SRAM address order, read throttling and stall stability
  initial begin
    int          n_iss = 0;
    int          n_pop = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_beat = '0;
    logic        pop;
    beat_t       b;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_iss = 0;
        n_pop = 0;
        prev_stall = 1'b0;
      end else begin
        pop = bus.st_valid & bus.st_ready;
        if (prev_stall)
          chk("stall_hold", {bus.st_valid, bus.st_data, bus.st_sop, bus.st_eop}, {1'b1, prev_beat});
        if (bus.sram_chipselect) begin
          checks++;
          if (n_iss - n_pop - int'(pop) >= 2) begin
            failures++;
            $display("FAIL cs_occupancy actual=%0d expected=<2", n_iss - n_pop - int'(pop));
          end
          if (addr_exp_q.size() == 0)
            fail_now("unexpected_read", int'(bus.sram_address), -1);
          else
            chk("sram_address", 64'(bus.sram_address), 64'(addr_exp_q.pop_front()));
        end
        if (pop) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat", int'(bus.st_data), -1);
          end else begin
            b = exp_q.pop_front();
            chk("st_beat", {bus.st_data, bus.st_sop, bus.st_eop}, {b.data, b.sop, b.eop});
          end
        end
        prev_stall = bus.st_valid & ~bus.st_ready;
        prev_beat  = {bus.st_data, bus.st_sop, bus.st_eop};
        n_iss += int'(bus.sram_chipselect);
        n_pop += int'(pop);
      end
    end
  end

  task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.ctrl_chipselect = 1'b1;
    bus.ctrl_write      = 1'b1;
    bus.ctrl_address    = a;
    bus.ctrl_writedata  = d;
    @(posedge clk);
    #1;
    bus.ctrl_chipselect = 1'b0;
    bus.ctrl_write      = 1'b0;
  endtask

  task automatic ctrl_rd(input logic [1:0] a, output logic [31:0] d);
    bus.ctrl_chipselect = 1'b1;
    bus.ctrl_read       = 1'b1;
    bus.ctrl_address    = a;
    #1;
    d = bus.ctrl_readdata;
    bus.ctrl_chipselect = 1'b0;
    bus.ctrl_read       = 1'b0;
    #1;
  endtask

  task automatic expect_words(input int start, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = mem[(start + i) % 2048];
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      exp_q.push_back(b);
      addr_exp_q.push_back((start + i) % 2048);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || addr_exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int start, input int len_wr, input int mode);
    int          len;
    logic [31:0] d;
    len = (len_wr > 2048) ? 2048 : len_wr;
    ready_mode = mode;
    ctrl_wr(2'd0, 32'(start));
    ctrl_wr(2'd1, 32'(len_wr));
    expect_words(start, len);
    ctrl_wr(2'd2, 32'h5);
    drain(len * 4 + 50);
    ctrl_rd(2'd2, d);
    chk("status_after_run", 64'(d[2:0]), 64'(3'b010));
    ctrl_rd(2'd3, d);
    chk("remain_after_run", 64'(d), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          base;
    int          n;

    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0A0_0000 + i;

    reset = 1'b1;
    bus.ctrl_address    = '0;
    bus.ctrl_chipselect = 1'b0;
    bus.ctrl_write      = 1'b0;
    bus.ctrl_writedata  = '0;
    bus.ctrl_read       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {bus.st_valid, bus.st_sop, bus.st_eop, bus.st_data,
                          bus.sram_chipselect, bus.sram_address, bus.irq, bus.ctrl_readdata[0]}, 64'd0);
    for (int a = 0; a < 4; a++) begin
      ctrl_rd(2'(a), d);
      chk("reset_reg", 64'(d), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 4 words from 0x010 with ready held high: latency and back-to-back beats
    ready_mode = 0;
    ctrl_wr(2'd0, 32'h10);
    ctrl_wr(2'd1, 32'd4);
    expect_words(16, 4);
    ctrl_wr(2'd2, 32'h5);
    ctrl_rd(2'd3, d);
    chk("remain_start", 64'(d), 64'd4);
    @(negedge clk);
    chk("valid_go_plus0", 64'(bus.st_valid), 64'd0);
    @(negedge clk);
    chk("valid_go_plus1", 64'(bus.st_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("valid_burst", 64'(bus.st_valid), 64'd1);
    end
    @(negedge clk);
    chk("valid_after_burst", 64'(bus.st_valid), 64'd0);
    drain(20);
    ctrl_rd(2'd2, d);
    chk("done_after_a3", 64'(d[2:0]), 64'(3'b010));

    // address wrap at the top of memory
    run(32'h7FE, 4, 0);

    // 16 words under random backpressure
    run(int'($urandom_range(0, 2047)), 16, 1);

    // zero-length GO with irq enabled
    ready_mode = 0;
    ctrl_wr(2'd1, 32'd0);
    ctrl_wr(2'd2, 32'h7);
    @(negedge clk);
    ctrl_rd(2'd2, d);
    chk("zero_len_edge0", 64'(d[2:0]), 64'(3'b100));
    @(negedge clk);
    ctrl_rd(2'd2, d);
    chk("zero_len_done", 64'(d[2:0]), 64'(3'b110));
    chk("irq_set", 64'(bus.irq), 64'd1);
    ctrl_wr(2'd2, 32'h6);
    chk("irq_cleared", 64'(bus.irq), 64'd0);
    ctrl_rd(2'd2, d);
    chk("done_cleared", 64'(d[2:0]), 64'(3'b100));

    // second GO and START write while busy are ignored
    ctrl_wr(2'd0, 32'd100);
    ctrl_wr(2'd1, 32'd8);
    expect_words(100, 8);
    ctrl_wr(2'd2, 32'h5);
    ctrl_wr(2'd0, 32'd300);
    ctrl_wr(2'd2, 32'h1);
    ctrl_rd(2'd0, d);
    chk("start_held_busy", 64'(d), 64'd100);
    drain(80);

    // reset after the 3rd accepted word
    ctrl_wr(2'd2, 32'h5);
    base = beats_seen;
    expect_words(100, 8);
    n = 0;
    while (beats_seen < base + 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("third_word_timeout", beats_seen - base, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midop_reset_outputs", {bus.st_valid, bus.st_sop, bus.st_eop, bus.st_data,
                                bus.sram_chipselect, bus.sram_address, bus.irq}, 64'd0);
    ctrl_rd(2'd2, d);
    chk("midop_reset_status", 64'(d), 64'd0);
    ctrl_rd(2'd3, d);
    chk("midop_reset_remain", 64'(d), 64'd0);
    exp_q.delete();
    addr_exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 2047)), int'($urandom_range(1, 40)), int'($urandom_range(0, 1)));

    // length saturation and a full-memory transfer
    ctrl_wr(2'd1, 32'hFFF);
    ctrl_rd(2'd1, d);
    chk("length_saturate", 64'(d), 64'h800);
    run(int'($urandom_range(0, 2047)), 32'hFFF, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
